// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
// Address width is derived from depth through rf_aw.
package regfile_pkg;

  localparam int RF_WIDTH = 16;
  localparam int RF_DEPTH = 32;

  function automatic int rf_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef logic [rf_aw(RF_DEPTH)-1:0] rf_addr_t;
  typedef logic [RF_WIDTH-1:0]        rf_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for multi-cycle producers.
// A busy-set beats a same-cycle writeback clear.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH   = RF_DEPTH,
  parameter int NWR     = 2,
  parameter int ZERO_R0 = 1,
  localparam int AW     = rf_aw(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bs_en,
  input  logic [AW-1:0]     bs_addr,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  output logic [DEPTH-1:0]  busy_vec
);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_next;

  always_comb begin
    w_next = r_busy;
    for (int r = 0; r < DEPTH; r++) begin
      for (int p = 0; p < NWR; p++)
        if (wr_en[p] && wr_addr[p*AW +: AW] == AW'(r))
          w_next[r] = 1'b0;
      if (bs_en && bs_addr == AW'(r))
        w_next[r] = 1'b1;
    end
    if (ZERO_R0 != 0)
      w_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_busy <= '0;
    else
      r_busy <= w_next;
  end

  assign busy_vec = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: storage, write arbitration, read/bypass.
// Highest-index write port wins on every conflict.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH   = RF_WIDTH,
  parameter int DEPTH   = RF_DEPTH,
  parameter int NRD     = 2,
  parameter int NWR     = 2,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1,
  parameter int AW      = rf_aw(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*WIDTH-1:0] wr_data,
  input  logic                 bs_en,
  input  logic [AW-1:0]        bs_addr,
  output logic [DEPTH-1:0]     busy_vec
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] w_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < DEPTH; r++)
        r_mem[r] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++)
        for (int r = 0; r < DEPTH; r++)
          if (wr_en[p] &&
              wr_addr[p*AW +: AW] == AW'(r) &&
              !(ZERO_R0 != 0 && r == 0))
            r_mem[r] <= wr_data[p*WIDTH +: WIDTH];
    end
  end

  // Only in-range addresses can hit storage or bypass.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      for (int r = 0; r < DEPTH; r++) begin
        if (rd_addr[k*AW +: AW] == AW'(r)) begin
          rd_data[k*WIDTH +: WIDTH] = r_mem[r];
          rd_busy[k] = w_busy[r];
          if (BYPASS != 0)
            for (int p = 0; p < NWR; p++)
              if (wr_en[p] && wr_addr[p*AW +: AW] == AW'(r))
                rd_data[k*WIDTH +: WIDTH] =
                  wr_data[p*WIDTH +: WIDTH];
        end
      end
      if (!rst ||
          (ZERO_R0 != 0 && rd_addr[k*AW +: AW] == '0)) begin
        rd_data[k*WIDTH +: WIDTH] = '0;
        rd_busy[k] = 1'b0;
      end
    end
  end

  regfile_scoreboard #(
    .DEPTH   (DEPTH),
    .NWR     (NWR),
    .ZERO_R0 (ZERO_R0)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .bs_en    (bs_en),
    .bs_addr  (bs_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .busy_vec (w_busy)
  );

  assign busy_vec = w_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: model-checked bypass and no-bypass copies
// on shared stimulus, plus a directed wide/odd-depth instance.
module tb_regfile_mp;

  logic clk;
  logic rst;

  logic [9:0]  rd_addr;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic        bs_en;
  logic [4:0]  bs_addr;

  logic [31:0] m_rd_data, n_rd_data;
  logic [1:0]  m_rd_busy, n_rd_busy;
  logic [31:0] m_busy, n_busy;

  logic [14:0] s_rd_addr;
  logic [95:0] s_rd_data;
  logic [2:0]  s_rd_busy;
  logic [0:0]  s_wr_en;
  logic [4:0]  s_wr_addr;
  logic [31:0] s_wr_data;
  logic        s_bs_en;
  logic [4:0]  s_bs_addr;
  logic [23:0] s_busy;

  int n_chk  = 0;
  int n_pass = 0;

  regfile_mp u_m (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(m_rd_data), .rd_busy(m_rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .bs_en(bs_en), .bs_addr(bs_addr), .busy_vec(m_busy)
  );

  regfile_mp #(.BYPASS(0)) u_n (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(n_rd_data), .rd_busy(n_rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .bs_en(bs_en), .bs_addr(bs_addr), .busy_vec(n_busy)
  );

  regfile_mp #(.WIDTH(32), .DEPTH(24), .NRD(3), .NWR(1)) u_s (
    .clk(clk), .rst(rst),
    .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_busy(s_rd_busy),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .bs_en(s_bs_en), .bs_addr(s_bs_addr), .busy_vec(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s @%0t: got %0h expected %0h",
               nm, $time, got, exp);
  endtask

  // Architectural model of the 32x16 file with R0 hardwired.
  logic [15:0] m_mem [32];
  bit          m_bsy [32];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 32; r++) begin
        m_mem[r] = '0;
        m_bsy[r] = 1'b0;
      end
    end else begin
      for (int p = 0; p < 2; p++)
        if (wr_en[p] && wr_addr[p*5 +: 5] != 5'd0) begin
          m_mem[wr_addr[p*5 +: 5]] = wr_data[p*16 +: 16];
          m_bsy[wr_addr[p*5 +: 5]] = 1'b0;
        end
      if (bs_en && bs_addr != 5'd0)
        m_bsy[bs_addr] = 1'b1;
    end
  end

  function automatic logic [15:0] model_rd(input int a, input bit byp);
    if (!rst || a == 0) return 16'h0;
    if (byp)
      for (int p = 1; p >= 0; p--)
        if (wr_en[p] && int'(wr_addr[p*5 +: 5]) == a)
          return wr_data[p*16 +: 16];
    return m_mem[a];
  endfunction

  function automatic logic [31:0] model_bv();
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = m_bsy[r];
    return v;
  endfunction

  int ca;
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      ca = int'(rd_addr[k*5 +: 5]);
      chk("m_rd_data", 64'(m_rd_data[k*16 +: 16]), 64'(model_rd(ca, 1)));
      chk("n_rd_data", 64'(n_rd_data[k*16 +: 16]), 64'(model_rd(ca, 0)));
      chk("m_rd_busy", 64'(m_rd_busy[k]), 64'(m_bsy[ca]));
      chk("n_rd_busy", 64'(n_rd_busy[k]), 64'(m_bsy[ca]));
    end
    chk("m_busy_vec", 64'(m_busy), 64'(model_bv()));
    chk("n_busy_vec", 64'(n_busy), 64'(model_bv()));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = '0;
    bs_en = 1'b0;
    s_wr_en = '0;
    s_bs_en = 1'b0;
  endtask

  task automatic wr(input int p, input int a, input logic [15:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*5 +: 5] = 5'(a);
    wr_data[p*16 +: 16] = d;
  endtask

  initial begin
    rst = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; bs_addr = '0;
    s_rd_addr = '0; s_wr_addr = '0; s_wr_data = '0; s_bs_addr = '0;
    idle();
    mid();
    chk("rst_rd", 64'(m_rd_data), 64'h0);
    chk("rst_bv", 64'(m_busy), 64'h0);
    repeat (2) tick();
    rst = 1'b1;

    // Reset: r5 written and busy, then async reset mid-cycle
    tick();
    wr(0, 5, 16'hBEEF); bs_en = 1'b1; bs_addr = 5'd5;
    tick();
    idle(); rd_addr = {5'd0, 5'd5};
    mid();
    chk("r5_pre", 64'(m_rd_data[15:0]), 64'hBEEF);
    chk("r5_busy_pre", 64'(m_rd_busy[0]), 64'h1);
    tick();
    rst = 1'b0;
    #1;
    chk("r5_in_rst", 64'(m_rd_data[15:0]), 64'h0);
    chk("bv_in_rst", 64'(m_busy), 64'h0);
    tick();
    rst = 1'b1;
    tick();
    mid();
    chk("r5_post", 64'(m_rd_data[15:0]), 64'h0);

    // Dual write and write-write conflict
    tick();
    wr(0, 3, 16'h1111); wr(1, 4, 16'h2222);
    rd_addr = {5'd4, 5'd3};
    mid();
    chk("byp_r3", 64'(m_rd_data[15:0]), 64'h1111);
    chk("byp_r4", 64'(m_rd_data[31:16]), 64'h2222);
    chk("nbyp_r3", 64'(n_rd_data[15:0]), 64'h0);
    tick();
    idle();
    mid();
    chk("st_r3", 64'(n_rd_data[15:0]), 64'h1111);
    chk("st_r4", 64'(n_rd_data[31:16]), 64'h2222);
    tick();
    wr(0, 7, 16'hAAAA); wr(1, 7, 16'h5555);
    rd_addr = {5'd3, 5'd7};
    mid();
    chk("byp_r7", 64'(m_rd_data[15:0]), 64'h5555);
    tick();
    idle();
    mid();
    chk("st_r7", 64'(n_rd_data[15:0]), 64'h5555);

    // Same-cycle bypass vs old data
    tick();
    wr(0, 9, 16'h1234); rd_addr = {5'd0, 5'd9};
    mid();
    chk("byp_r9", 64'(m_rd_data[15:0]), 64'h1234);
    chk("nbyp_r9", 64'(n_rd_data[15:0]), 64'h0);
    tick();
    idle();
    mid();
    chk("st_r9", 64'(n_rd_data[15:0]), 64'h1234);

    // R0 ignores writes and busy-sets
    tick();
    wr(1, 0, 16'hFFFF); bs_en = 1'b1; bs_addr = 5'd0;
    rd_addr = {5'd9, 5'd0};
    mid();
    chk("r0_byp", 64'(m_rd_data[15:0]), 64'h0);
    tick();
    idle();
    mid();
    chk("r0_st", 64'(m_rd_data[15:0]), 64'h0);
    chk("r0_bv", 64'(m_busy[0]), 64'h0);

    // Scoreboard set, writeback-cycle busy, clear, set-beats-clear
    tick();
    bs_en = 1'b1; bs_addr = 5'd6; rd_addr = {5'd6, 5'd6};
    tick();
    bs_en = 1'b1; bs_addr = 5'd6;
    mid();
    chk("sb_set", 64'(m_busy[6]), 64'h1);
    chk("sb_rd_busy", 64'(m_rd_busy[1]), 64'h1);
    tick();
    idle(); wr(0, 6, 16'h0606);
    mid();
    chk("sb_wb_busy", 64'(m_rd_busy[0]), 64'h1);
    tick();
    idle();
    mid();
    chk("sb_clr", 64'(m_busy[6]), 64'h0);
    tick();
    wr(1, 6, 16'h6666); bs_en = 1'b1; bs_addr = 5'd6;
    tick();
    idle();
    mid();
    chk("sb_setwin", 64'(m_busy[6]), 64'h1);
    chk("sb_data", 64'(n_rd_data[15:0]), 64'h6666);

    // Wide, odd-depth, three-reader instance
    tick();
    s_wr_en = 1'b1; s_wr_addr = 5'd30; s_wr_data = 32'hDEADBEEF;
    s_rd_addr = {5'd0, 5'd0, 5'd30};
    mid();
    chk("s_oor_byp", 64'(s_rd_data[31:0]), 64'h0);
    tick();
    idle(); s_bs_en = 1'b1; s_bs_addr = 5'd30;
    mid();
    chk("s_oor_st", 64'(s_rd_data[31:0]), 64'h0);
    tick();
    idle();
    mid();
    chk("s_oor_bv", 64'(s_busy), 64'h0);
    tick();
    s_wr_en = 1'b1; s_wr_addr = 5'd1; s_wr_data = 32'h11111111;
    tick();
    s_wr_addr = 5'd2; s_wr_data = 32'h22222222;
    tick();
    s_wr_addr = 5'd23; s_wr_data = 32'h33333333;
    s_rd_addr = {5'd23, 5'd2, 5'd1};
    mid();
    chk("s_rd0", 64'(s_rd_data[31:0]), 64'h11111111);
    chk("s_rd1", 64'(s_rd_data[63:32]), 64'h22222222);
    chk("s_rd2_byp", 64'(s_rd_data[95:64]), 64'h33333333);
    tick();
    idle();
    mid();
    chk("s_rd2_st", 64'(s_rd_data[95:64]), 64'h33333333);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
